// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetch entries with head/tail/count; flush is a synchronous clear.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fq_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t wdata_i,
  output entry_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[head_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_pop)  head_d = head_q + PTR_W'(1);
      if (do_push) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue pairing PC addresses with registered imem data; drops and redirects when full.
// Optional FQ_BYPASS_EN lets the pending fetch reach decode directly when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = fetch_pkg::ADDR_W,
  parameter int unsigned INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  ins_address,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  output logic               redirect_en,
  output logic [ADDR_W-1:0]  redirect_target,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic [INSTR_W-1:0] dec_instr
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              q_full, q_empty;
  logic              pop, space, push, fifo_pop, byp;
  entry_t            head, wr;

  assign wr = '{pc: pend_pc_q, instr: imem_rdata};

  fq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .wdata_i (wr),
    .rdata_o (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Handshake, space/drop decision and decode output mux.
  always_comb begin
    byp = 1'b0;
`ifdef FQ_BYPASS_EN
    byp = q_empty & pend_valid_q & ~flush;
`endif
    dec_valid = ~q_empty | byp;
    dec_pc    = '0;
    dec_instr = '0;
    if (!q_empty) begin
      dec_pc    = head.pc;
      dec_instr = head.instr;
    end else if (byp) begin
      dec_pc    = pend_pc_q;
      dec_instr = imem_rdata;
    end
    pop             = dec_valid & dec_ready;
    space           = ~q_full | pop;
    redirect_en     = pend_valid_q & ~space & ~flush;
    redirect_target = redirect_en ? pend_pc_q : '0;
    // A bypassed entry consumed this cycle never enters storage.
    push            = pend_valid_q & space & ~flush & ~(byp & pop);
    fifo_pop        = pop & ~q_empty;
    pend_valid_d    = ~(reset | flush | redirect_en);
  end

  always_ff @(posedge clk) begin
    pend_pc_q    <= ins_address;
    pend_valid_q <= pend_valid_d;
  end

endmodule
